// File: rtl/md_pkg.sv
// md_sequencer shared package: op codes, latency defaults, op classifiers.
// MADD/MADDU/MSUB/MSUBU are multi-cycle only when MD_MADD_EN is defined.
package md_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } md_state_e;

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_multi(input logic [3:0] op);
    logic m;
    m = (op == OP_MULT) || (op == OP_MULTU) || is_div(op);
`ifdef MD_MADD_EN
    m = m || (op == OP_MADD) || (op == OP_MADDU)
          || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return m;
  endfunction

endpackage

// File: rtl/md_if.sv
// md_sequencer E-stage bundle: start/op/operands in, busy and HI/LO out.
interface md_if;
  import md_pkg::*;

  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, hi, lo
  );

endinterface

// File: rtl/md_arith.sv
// md_arith: combinational next-{hi,lo} for mult/div and (MD_MADD_EN)
// multiply-accumulate paths; one shared magnitude divider.
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_res
);

  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic        w_sgn;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_dvs_nz;
  logic [31:0] w_qm;
  logic [31:0] w_rm;
  logic [31:0] w_q;
  logic [31:0] w_r;

  // low 64 bits of a sign-extended 64x64 product equal the signed product
  assign w_sprod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

  assign w_sgn    = (i_op == OP_DIV);
  assign w_a_neg  = w_sgn & i_a[31];
  assign w_b_neg  = w_sgn & i_b[31];
  assign w_dvd    = w_a_neg ? -i_a : i_a;
  assign w_dvs    = w_b_neg ? -i_b : i_b;
  assign w_dvs_nz = (w_dvs == 32'd0) ? 32'd1 : w_dvs;
  assign w_qm     = w_dvd / w_dvs_nz;
  assign w_rm     = w_dvd % w_dvs_nz;
  assign w_q      = (w_a_neg ^ w_b_neg) ? -w_qm : w_qm;
  assign w_r      = w_a_neg ? -w_rm : w_rm;

  always_comb begin
    o_res = {i_hi, i_lo};
    case (i_op)
      OP_MULT:  o_res = w_sprod;
      OP_MULTU: o_res = w_uprod;
      OP_DIV,
      OP_DIVU: begin
        if (i_b == 32'd0) o_res = {i_a, 32'hFFFF_FFFF};
        else              o_res = {w_r, w_q};
      end
`ifdef MD_MADD_EN
      OP_MADD:  o_res = {i_hi, i_lo} + w_sprod;
      OP_MADDU: o_res = {i_hi, i_lo} + w_uprod;
      OP_MSUB:  o_res = {i_hi, i_lo} - w_sprod;
      OP_MSUBU: o_res = {i_hi, i_lo} - w_uprod;
`endif
      default:  o_res = {i_hi, i_lo};
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: HI/LO owner running fixed-latency mult/div beside the ALU.
// Optional MD_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate ops.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic  clk,
  input logic  reset,
  md_if.slave  md
);

  localparam logic [3:0] L_MUL = 4'(MUL_CYCLES);
  localparam logic [3:0] L_DIV = 4'(DIV_CYCLES);

  md_state_e   r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  md_state_e   w_state_nx;
  logic [3:0]  w_cnt_nx;
  logic        w_load;
  logic        w_commit;
  logic        w_wr_hi;
  logic        w_wr_lo;
  logic [63:0] w_res;

  md_arith u_arith (
    .i_op  (r_op),
    .i_a   (r_a),
    .i_b   (r_b),
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .o_res (w_res)
  );

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_load     = 1'b0;
    w_commit   = 1'b0;
    w_wr_hi    = 1'b0;
    w_wr_lo    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (md.start) begin
          if (is_multi(md.op)) begin
            w_load     = 1'b1;
            w_state_nx = S_RUN;
            w_cnt_nx   = is_div(md.op) ? L_DIV : L_MUL;
          end else begin
            w_wr_hi = (md.op == OP_MTHI);
            w_wr_lo = (md.op == OP_MTLO);
          end
        end
      end
      S_RUN: begin
        w_cnt_nx = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_commit   = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_op    <= 4'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_load) begin
        r_op <= md.op;
        r_a  <= md.a;
        r_b  <= md.b;
      end
      if (w_commit) begin
        r_hi <= w_res[63:32];
        r_lo <= w_res[31:0];
      end
      if (w_wr_hi) r_hi <= md.a;
      if (w_wr_lo) r_lo <= md.a;
    end
  end

  assign md.busy = (r_state == S_RUN);
  assign md.hi   = r_hi;
  assign md.lo   = r_lo;

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multiply/divide sequencer for the five-stage MIPS pipeline. Sits beside the ALU in the E stage and accepts one HI/LO operation per start pulse. It runs a fixed-latency multi-cycle multiply or divide, owns the HI and LO registers, and drives `busy` to the hazard unit so that later mult/div/mfhi/mflo/mthi/mtlo instructions are held in D until the result is committed.

## Interface
- `MUL_CYCLES`, default 5: cycles from accepted multiply start to HI/LO commit.
- `DIV_CYCLES`, default 10: cycles from accepted divide start to HI/LO commit.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `reset` in, 1: synchronous, active-high.
- `start` in, 1: E-stage instruction is a HI/LO op; sampled on the rising edge.
- `op` in, 4: operation code from the shared package (MULT, MULTU, DIV, DIVU, MTHI, MTLO; MADD, MADDU, MSUB, MSUBU under `MD_MADD_EN`).
- `a` in, 32: forwarded rs value.
- `b` in, 32: forwarded rt value.
- `busy` out, 1: a multi-cycle operation is in flight.
- `hi` out, 32: HI register.
- `lo` out, 32: LO register.

## Operation
- States: IDLE and RUN. A down-counter `cnt` of 4 bits holds the remaining cycles.
- IDLE, with `start` and a multi-cycle op:
  - Latch `op`, `a` and `b`.
  - Load `cnt` with MUL_CYCLES or DIV_CYCLES.
  - Go to RUN.
- IDLE, with `start` and MTHI or MTLO: write `a` into hi or lo at that edge. No RUN state and `busy` stays 0.
- RUN: decrement `cnt` each cycle. The cycle in which `cnt` reaches 1 writes the latched result to hi/lo and returns to IDLE.
- `start` during RUN is ignored: no latch, no HI/LO write. The hazard unit guarantees it never occurs. The bench checks that it is dropped.
- `busy` = (state == RUN). It is registered and carries no combinational path from `start`.
- MULT: signed 32x32 gives a 64-bit product; hi = [63:32], lo = [31:0].
- MULTU: the same, unsigned.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- DIVU: the same, unsigned.
- Divide by zero (`b` == 0, DIV or DIVU): hi = `a`, lo = 32'hFFFF_FFFF. Latency is unchanged.
- DIV of 32'h8000_0000 by 32'hFFFF_FFFF: lo = 32'h8000_0000, hi = 0.
- Results are computed from the operands latched at start. Changes on `a` or `b` during RUN have no effect.

## Timing
- Reset values: state IDLE, `cnt` = 0, `busy` = 0, `hi` = 0, `lo` = 0.
- Multiply accepted at edge T:
  - `busy` = 1 from T through T+MUL_CYCLES-1.
  - hi/lo update and `busy` falls at edge T+MUL_CYCLES.
- Divide: identical, using DIV_CYCLES.
- A new `start` is accepted at the same edge where `busy` falls only if that edge sees `busy` already low. The first acceptable edge is T+N+1 relative to the previous start.
- MTHI/MTLO take effect at the accepting edge; the new value is visible the next cycle.
- `reset` during RUN aborts the operation: no partial commit, and hi/lo return to 0.

## Configuration
- `MD_MADD_EN` defined:
  - MADD/MADDU: {hi,lo} += product, signed or unsigned respectively.
  - MSUB/MSUBU: {hi,lo} -= product, signed or unsigned respectively.
  - Arithmetic is modulo 2^64 and latency is MUL_CYCLES.
  - The accumulator is read at commit, not at start.
- `MD_MADD_EN` undefined: those four codes are treated as no-ops. The block stays IDLE, `busy` stays 0, and hi/lo are unchanged.

## Structure
- Shared package `md_pkg`:
  - The op code constants.
  - MUL_CYCLES_DEF and DIV_CYCLES_DEF.
  - A helper that reports whether an op is multi-cycle.
- Sub-module `md_arith`: purely combinational. It takes the latched op, a, b, hi and lo and produces the 64-bit next {hi,lo}, covering signed/unsigned product, divide, divide-by-zero and the MADD/MSUB paths.
- `md_sequencer` contains only the FSM, the counter, the operand latches and the HI/LO registers.

## Test plan
- MULT with a = 32'hFFFF_FFFE (-2), b = 3: `busy` is high for 5 cycles, then hi = 32'hFFFF_FFFF and lo = 32'hFFFF_FFFA.
- DIVU with a = 7, b = 2: after 10 busy cycles, hi = 1 and lo = 3. DIV with a = -7, b = 2: hi = 32'hFFFF_FFFF (-1) and lo = 32'hFFFF_FFFD (-3).
- DIV with a = 5, b = 0: hi = 5 and lo = 32'hFFFF_FFFF after 10 cycles.
- MTHI with a = 32'h1234 while IDLE: hi = 32'h1234 the next cycle and `busy` never rises. An MTLO pulsed during a MULT's RUN is ignored, and lo equals the product.
- MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF, with `reset` asserted on the 3rd busy cycle: `busy` = 0 and hi = lo = 0 on the next cycle, and no later commit occurs.
- With `MD_MADD_EN`: hi = 0 and lo = 32'hFFFF_FFFF, then MADDU a = 1, b = 1 gives hi = 1 and lo = 0.
